// File: rtl/mem_io_bridge.sv
// mem_io_bridge: CPU-visible data RAM plus a small memory-mapped I/O block
// (camera pixel FIFO with status/control registers, an LED register and an
// optional cycle counter).
//
// Optional feature: define MEM_IO_CYCLE_COUNTER_EN to build the free-running
// 32-bit CYCLES counter. Without it, CYCLES reads as zero and no counter exists.
//
// Address map (word aligned, WriteAddress[1:0] ignored):
//   0x0000_0000..0x0000_03FF  RAM (index WriteAddress[9:2] modulo RAM_WORDS)
//   0x0001_0000               FIFO_STATUS {ovf[10], full[9], empty[8], count[4:0]}
//   0x0001_0004               FIFO_DATA   head pixel, 0 when empty
//   0x0001_0008               FIFO_CTRL   write-only {flush[2], clr_ovf[1], pop[0]}
//   0x0001_000C               LED         8-bit read/write
//   0x0001_0010               CYCLES      read-only
module mem_io_bridge #(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_enable,
    input  logic [31:0] WriteAddress,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic        cam_valid,
    input  logic [7:0]  cam_pixel,
    output logic        cam_ready,
    output logic [7:0]  led
);

    localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    // Word addresses (byte address >> 2) of the I/O registers
    localparam logic [29:0] WADDR_STATUS = 30'h0000_4000;
    localparam logic [29:0] WADDR_DATA   = 30'h0000_4001;
    localparam logic [29:0] WADDR_CTRL   = 30'h0000_4002;
    localparam logic [29:0] WADDR_LED    = 30'h0000_4003;
    localparam logic [29:0] WADDR_CYCLES = 30'h0000_4004;

    logic [31:0]       ram [RAM_WORDS];
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [31:0]       cycles_value;

    logic [29:0]       word_addr;
    logic [RAM_AW-1:0] ram_idx;
    logic              sel_ram;
    logic              sel_status;
    logic              sel_data;
    logic              sel_ctrl;
    logic              sel_led;
    logic              sel_cycles;

    logic              store_ok;
    logic              ctrl_write;
    logic              fifo_empty;
    logic              fifo_full;
    logic              do_push;
    logic              do_pop;
    logic              do_flush;
    logic              clr_ovf;
    logic              set_ovf;
    logic [4:0]        count_field;
    logic              unused_addr_bits;

    assign word_addr  = WriteAddress[31:2];
    assign ram_idx    = WriteAddress[RAM_AW+1:2];
    assign sel_ram    = (WriteAddress[31:10] == 22'd0);
    assign sel_status = (word_addr == WADDR_STATUS);
    assign sel_data   = (word_addr == WADDR_DATA);
    assign sel_ctrl   = (word_addr == WADDR_CTRL);
    assign sel_led    = (word_addr == WADDR_LED);
    assign sel_cycles = (word_addr == WADDR_CYCLES);

    // Byte-offset bits have no meaning in a word-addressed map
    assign unused_addr_bits = ^WriteAddress[1:0];

    // Stores are suppressed entirely while reset is asserted
    assign store_ok   = write_enable && !reset;
    assign ctrl_write = store_ok && sel_ctrl;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));

    // Flush empties the FIFO first, so a pop in the same write has nothing to
    // remove; the pointer/count block therefore lets flush override everything.
    assign do_flush  = ctrl_write && WriteData[2];
    assign do_pop    = ctrl_write && WriteData[0] && !fifo_empty;
    assign clr_ovf   = ctrl_write && WriteData[1];
    assign cam_ready = !fifo_full && !reset;
    assign do_push   = cam_valid && cam_ready;
    assign set_ovf   = cam_valid && fifo_full;

    assign count_field = 5'(count);

    // Data RAM: write-through on the store edge, never reset
    always_ff @(posedge clk) begin
        if (store_ok && sel_ram) begin
            ram[ram_idx] <= WriteData;
        end
    end

    // Pixel storage: written at the tail whenever a push is accepted
    always_ff @(posedge clk) begin
        if (do_push && !do_flush) begin
            fifo_mem[wr_ptr] <= cam_pixel;
        end
    end

    // FIFO pointers and occupancy; flush wins over a concurrent push or pop
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (do_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow: a dropped pixel in the same cycle beats a clear request
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (set_ovf) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // LED register keeps only the low byte of the store data
    always_ff @(posedge clk) begin
        if (reset) begin
            led <= 8'h00;
        end else if (store_ok && sel_led) begin
            led <= WriteData[7:0];
        end
    end

`ifdef MEM_IO_CYCLE_COUNTER_EN
    logic [31:0] cycle_count;

    // Free-running cycle counter, wraps naturally at 32 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= 32'd0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    assign cycles_value = cycle_count;
`else
    assign cycles_value = 32'd0;
`endif

    // Load path: purely combinational, reads never disturb any state
    always_comb begin
        ReadData = 32'd0;
        if (sel_ram) begin
            ReadData = ram[ram_idx];
        end else if (sel_status) begin
            ReadData = {21'd0, overflow, fifo_full, fifo_empty, 3'd0, count_field};
        end else if (sel_data) begin
            ReadData = fifo_empty ? 32'd0 : {24'd0, fifo_mem[rd_ptr]};
        end else if (sel_led) begin
            ReadData = {24'd0, led};
        end else if (sel_cycles) begin
            ReadData = cycles_value;
        end
    end

endmodule
